// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: host push side and transmitter handshake bundle for uart_tx_feeder.
interface uart_tx_feeder_if #(parameter int DEPTH = 16);
   localparam int CW = $clog2(DEPTH) + 1;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          flush;
   logic          clr_ovf;
   logic          tx_rdy;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          busy;
   modport master (
      output wr_en, wr_data, flush, clr_ovf, tx_rdy,
      input  tx_start, tx_data, full, empty, count, overflow, busy
   );
   modport slave (
      input  wr_en, wr_data, flush, clr_ovf, tx_rdy,
      output tx_start, tx_data, full, empty, count, overflow, busy
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that launches one byte at a time into an idle UART transmitter.
module uart_tx_feeder #(parameter int DEPTH = 16) (
   input logic             clk,
   input logic             rst,
   uart_tx_feeder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, START, WAIT_LO, WAIT_HI} state_t;
   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [7:0]    tx_data;
   logic          tx_start, overflow, full, empty, push, pop;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   // flush wins over both the host write and the launch pop
   assign push  = bus.wr_en && !full && !bus.flush;
   assign pop   = state == IDLE && !empty && bus.tx_rdy && !bus.flush;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.wr_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
         if (bus.wr_en && full && !bus.flush) overflow <= 1'b1;
         else if (bus.clr_ovf) overflow <= 1'b0;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         case (state)
            IDLE: if (pop) begin
               tx_data  <= mem[rd_ptr];
               tx_start <= 1'b1;
               state    <= START;
            end
            START: begin
               tx_start <= 1'b0;
               state    <= WAIT_LO;
            end
            WAIT_LO: if (!bus.tx_rdy) state <= WAIT_HI;
            WAIT_HI: if (bus.tx_rdy) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   assign bus.tx_start = tx_start;
   assign bus.tx_data  = tx_data;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.count    = count;
   assign bus.overflow = overflow;
   assign bus.busy     = state != IDLE || !empty;
endmodule
